// File: rtl/toggle_mem_pkg.sv
// Shared types and constants for the toggle-request memory responder.
// Contents: FSM state type, byte-lane enable encodings, wait-counter width.
package toggle_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    // Wait counter width; supports WAIT_CYCLES in 0..15.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/toggle_mem_bram.sv
// 16-bit word RAM with per-byte write enables and a registered read port,
// written in the canonical shape that maps onto block RAM.
// Ports:
//   clk    - clock
//   addr   - word address
//   we_hi  - write enable for bits [15:8]
//   we_lo  - write enable for bits [7:0]
//   wdata  - write data
//   rdata  - registered read data (word at addr on the previous edge)
module toggle_mem_bram #(
    parameter int WAW = 15
) (
    input  logic           clk,
    input  logic [WAW-1:0] addr,
    input  logic           we_hi,
    input  logic           we_lo,
    input  logic [15:0]    wdata,
    output logic [15:0]    rdata
);

    logic [15:0] mem [2**WAW];

    // NOTE: the array has no reset on purpose -- a reset branch would stop
    // the tools from mapping it onto block RAM, and contents must survive
    // init_n anyway.
    always_ff @(posedge clk) begin
        if (we_hi) mem[addr][15:8] <= wdata[15:8];
        if (we_lo) mem[addr][7:0]  <= wdata[7:0];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/toggle_mem_responder.sv
// Responder end of the toggle-request memory port: a change of port_req
// relative to port_ack is a request; port_ack toggles once it is served.
// Requests are served from an internal 16-bit block-RAM word array.
// Ports:
//   clk, init_n        - clock, asynchronous active-low reset
//   port_req/port_ack  - request / acknowledge toggles
//   port_a             - byte address (a[AW-1:1] word, a[0] read byte)
//   port_ds            - byte enables {hi, lo}
//   port_we            - 1 = write, 0 = read
//   port_d             - write data
//   port_q             - read byte, valid from the ack toggle
//   busy               - high from request acceptance until ack toggles
//   rd_count/wr_count  - completed read/write counters (RESP_STATS_EN only)
// Optional build macro: RESP_STATS_EN adds the saturating counters.
module toggle_mem_responder
    import toggle_mem_pkg::*;
#(
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int SYNC_REQ    = 0
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic [7:0]    port_q,
    output logic          busy
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
`endif
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [AW-1:0]     a_q;
    logic [1:0]        ds_q;
    logic              we_q;
    logic [15:0]       d_q;
    logic              req_s;
    logic              pending;
    logic              op_fire;
    logic [AW-2:0]     ram_addr;
    logic [15:0]       ram_rdata;

    if (SYNC_REQ != 0) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk or negedge init_n) begin
            if (!init_n) sync_q <= 2'b00;
            else         sync_q <= {sync_q[0], port_req};
        end
        assign req_s = sync_q[1];
    end else begin : g_nosync
        assign req_s = port_req;
    end

    assign pending = (req_s != port_ack);
    assign op_fire = (state_q == ACCESS) && (cnt_q == '0);

    // In IDLE the live address is presented so that with WAIT_CYCLES=0 the
    // registered read is already under way on the entry edge; afterwards
    // the latched address keeps it stable for the operation edge.
    assign ram_addr = (state_q == IDLE) ? port_a[AW-1:1] : a_q[AW-1:1];

    toggle_mem_bram #(.WAW(AW-1)) u_bram (
        .clk   (clk),
        .addr  (ram_addr),
        .we_hi (op_fire && we_q && ((ds_q & DS_HI) != 2'b00)),
        .we_lo (op_fire && we_q && ((ds_q & DS_LO) != 2'b00)),
        .wdata (d_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            port_ack <= 1'b0;
            port_q   <= 8'h00;
            busy     <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            ds_q     <= 2'b00;
            we_q     <= 1'b0;
            d_q      <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        a_q   <= port_a;
                        ds_q  <= port_ds;
                        we_q  <= port_we;
                        d_q   <= port_d;
                        cnt_q <= WAIT_W'(WAIT_CYCLES);
                        busy  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else if (!we_q)  port_q <= a_q[0] ? ram_rdata[15:8] : ram_rdata[7:0];
                end
                DONE: begin
                    port_ack <= ~port_ack;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef RESP_STATS_EN
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else if (state_q == DONE) begin
            if (we_q) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_toggle_mem_responder.sv
// Self-checking bench for toggle_mem_responder.
// dut0: default build (WAIT_CYCLES=2, SYNC_REQ=0); dut1: WAIT_CYCLES=0,
// SYNC_REQ=1. Both share clock, reset and request payload buses.
module tb_toggle_mem_responder;

    logic        clk = 1'b0;
    logic        init_n;
    logic        req0, req1;
    logic [15:0] a, d;
    logic [1:0]  ds;
    logic        we;
    logic        ack0, ack1, busy0, busy1;
    logic [7:0]  q0, q1;
`ifdef RESP_STATS_EN
    logic [15:0] rc0, wc0, rc1, wc1;
`endif

    always #5 clk = ~clk;

    toggle_mem_responder #(.AW(16), .WAIT_CYCLES(2), .SYNC_REQ(0)) dut0 (
        .clk(clk), .init_n(init_n), .port_req(req0), .port_ack(ack0),
        .port_a(a), .port_ds(ds), .port_we(we), .port_d(d),
        .port_q(q0), .busy(busy0)
`ifdef RESP_STATS_EN
        , .rd_count(rc0), .wr_count(wc0)
`endif
    );

    toggle_mem_responder #(.AW(16), .WAIT_CYCLES(0), .SYNC_REQ(1)) dut1 (
        .clk(clk), .init_n(init_n), .port_req(req1), .port_ack(ack1),
        .port_a(a), .port_ds(ds), .port_we(we), .port_d(d),
        .port_q(q1), .busy(busy1)
`ifdef RESP_STATS_EN
        , .rd_count(rc1), .wr_count(wc1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: word arrays per DUT, expected read byte, op counts.
    logic [15:0] mem0 [int];
    logic [15:0] mem1 [int];
    logic [7:0]  q_exp [2];
    int          rds [2];
    int          wrs [2];

    function automatic logic ack_of(input int w);
        return (w == 0) ? ack0 : ack1;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [7:0] q_of(input int w);
        return (w == 0) ? q0 : q1;
    endfunction

    function automatic logic [15:0] model_word(input int w, input int idx);
        if (w == 0) return mem0.exists(idx) ? mem0[idx] : 16'hxxxx;
        return mem1.exists(idx) ? mem1[idx] : 16'hxxxx;
    endfunction

    function automatic void model_op(input int w, input bit wr, input logic [15:0] addr,
                                     input logic [1:0] lanes, input logic [15:0] data);
        int          idx;
        logic [15:0] m;
        idx = int'(addr[15:1]);
        m   = model_word(w, idx);
        if (wr) begin
            if (lanes[1]) m[15:8] = data[15:8];
            if (lanes[0]) m[7:0]  = data[7:0];
            if (w == 0) mem0[idx] = m; else mem1[idx] = m;
            wrs[w]++;
        end else begin
            q_exp[w] = addr[0] ? m[15:8] : m[7:0];
            rds[w]++;
        end
    endfunction

    // One full request/acknowledge handshake with latency and busy checks.
    task automatic txn(input int w, input bit wr, input logic [15:0] addr,
                       input logic [1:0] lanes, input logic [15:0] data, input string tag);
        int   n;
        int   lat;
        logic prev;
        lat = 3 + ((w == 0) ? 2 : 0) + ((w == 0) ? 0 : 2);
        @(negedge clk);
        a = addr; ds = lanes; we = wr; d = data;
        prev = ack_of(w);
        if (w == 0) req0 = ~req0; else req1 = ~req1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (w == 0 && ack_of(w) == prev) check({tag, "_busy"}, busy0, 1);
        end while (ack_of(w) == prev && n < 20);
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy_end"}, busy_of(w), 0);
        model_op(w, wr, addr, lanes, data);
        check({tag, "_q"}, q_of(w), q_exp[w]);
    endtask

    // Request followed by 'extra' further toggles while still busy.
    task automatic cancel_test(input int extra, input int exp_acks, input string tag);
        int   acks;
        logic prev;
        @(negedge clk);
        a = 16'h1235; ds = 2'b11; we = 1'b0; d = 16'h0000;
        prev = ack0;
        req0 = ~req0;
        for (int k = 0; k < extra; k++) begin
            @(posedge clk);
            @(negedge clk);
            req0 = ~req0;
        end
        acks = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ack0 != prev) begin
                acks++;
                prev = ack0;
                model_op(0, 1'b0, 16'h1235, 2'b11, 16'h0000);
            end
        end
        check({tag, "_acks"}, acks, exp_acks);
        check({tag, "_eq"}, ack0, req0);
        check({tag, "_q"}, q0, q_exp[0]);
    endtask

    logic [15:0] pool [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a = '0; d = '0; ds = 2'b00; we = 1'b0;
        q_exp[0] = 8'h00; q_exp[1] = 8'h00;
        rds[0] = 0; rds[1] = 0; wrs[0] = 0; wrs[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", ack0, 0);
        check("rst_q0", q0, 8'h00);
        check("rst_busy0", busy0, 0);
        check("rst_all1", {ack1, busy1, q1}, 0);
        @(negedge clk);
        init_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("idle", {ack0, busy0, ack1, busy1}, 0);
        end

        // Byte-lane write / read-back.
        txn(0, 1'b1, 16'h1234, 2'b01, 16'h3C3C, "pre_lo");
        txn(0, 1'b1, 16'h1235, 2'b10, 16'hA5A5, "wr_hi");
        check("wr_keeps_q", q0, 8'h00);
        txn(0, 1'b0, 16'h1235, 2'b11, 16'h0000, "rd_hi");
        check("rd_hi_val", q0, 8'hA5);
        txn(0, 1'b0, 16'h1234, 2'b11, 16'h0000, "rd_lo");
        check("rd_lo_val", q0, 8'h3C);

        // ds=00 write is acknowledged but leaves the word alone.
        txn(0, 1'b1, 16'h0100, 2'b11, 16'hBEEF, "beef");
        txn(0, 1'b1, 16'h0100, 2'b00, 16'h0000, "ds00");
        txn(0, 1'b0, 16'h0100, 2'b11, 16'h0000, "ds00_rd_lo");
        check("ds00_lo_val", q0, 8'hEF);
        txn(0, 1'b0, 16'h0101, 2'b11, 16'h0000, "ds00_rd_hi");
        check("ds00_hi_val", q0, 8'hBE);

        // Randomized traffic over a preloaded pool of words.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'($urandom) & 16'hFFFE;
            txn(0, 1'b1, pool[i], 2'b11, 16'($urandom), "pool");
        end
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [7:0]  b;
            bit          wr;
            ra = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1));
            b  = 8'($urandom);
            wr = 1'($urandom_range(0, 1));
            if (wr) txn(0, 1'b1, ra, 2'($urandom_range(0, 3)), {b, b}, "rnd_wr");
            else    txn(0, 1'b0, ra, 2'b11, 16'h0000, "rnd_rd");
        end

        // Synchronised, zero-wait instance including the top word.
        txn(1, 1'b1, 16'hFFFE, 2'b11, 16'h1357, "s_wr");
        txn(1, 1'b0, 16'hFFFE, 2'b11, 16'h0000, "s_rd_lo");
        check("s_rd_lo_val", q1, 8'h57);
        txn(1, 1'b0, 16'hFFFF, 2'b11, 16'h0000, "s_rd_hi");
        check("s_rd_hi_val", q1, 8'h13);

        // Extra toggles while busy.
        cancel_test(2, 1, "cancel2");
        cancel_test(3, 2, "cancel3");

`ifdef RESP_STATS_EN
        check("stats_rd0", rc0, rds[0]);
        check("stats_wr0", wc0, wrs[0]);
        check("stats_rd1", rc1, rds[1]);
        check("stats_wr1", wc1, wrs[1]);
`endif

        // Reset in the middle of ACCESS.
        @(negedge clk);
        a = 16'h1235; ds = 2'b11; we = 1'b0;
        req0 = ~req0;
        @(posedge clk);
        @(posedge clk);
        #1;
        init_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("abort_ack", ack0, 0);
        check("abort_busy", busy0, 0);
        check("abort_q", q0, 8'h00);
        q_exp[0] = 8'h00; q_exp[1] = 8'h00;
        rds[0] = 0; rds[1] = 0; wrs[0] = 0; wrs[1] = 0;
        @(negedge clk);
        init_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_abort_idle", {ack0, busy0}, 0);
        end

        // Memory survives reset; then 3 reads and 2 writes for the counters.
        txn(0, 1'b0, 16'h1234, 2'b11, 16'h0000, "keep_rd");
        check("keep_val", q0, 8'h3C);
        txn(0, 1'b1, 16'h2000, 2'b11, 16'h6699, "st_wr1");
        txn(0, 1'b1, 16'h2001, 2'b00, 16'h7777, "st_wr2");
        txn(0, 1'b0, 16'h2000, 2'b11, 16'h0000, "st_rd2");
        txn(0, 1'b0, 16'h2001, 2'b11, 16'h0000, "st_rd3");
`ifdef RESP_STATS_EN
        check("cnt_rd", rc0, 3);
        check("cnt_wr", wc0, 2);
        check("cnt_idle1", {rc1, wc1}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
